// File: rtl/irqc_pkg.sv
// Shared constants for the interrupt controller: register-select encodings
// and the width of the register data bus.
package irqc_pkg;

  localparam int IRQC_DW = 32;

  localparam logic [1:0] IRQC_ADDR_IMR = 2'd0;
  localparam logic [1:0] IRQC_ADDR_IRR = 2'd1;
  localparam logic [1:0] IRQC_ADDR_ISR = 2'd2;

endpackage : irqc_pkg

// File: rtl/irqc_prio_enc.sv
// Combinational fixed-priority encoder: reports whether any bit is set and
// the index of the lowest set bit (0 when nothing is set).
module irqc_prio_enc
  import irqc_pkg::*;
#(
  parameter int W    = 32,
  parameter int ID_W = 5
) (
  input  logic [W-1:0]    vec_i,
  output logic            valid_o,
  output logic [ID_W-1:0] id_o
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    id_o    = '0;
    valid_o = |vec_i;
    // Scanning downward lets the lowest set index overwrite any higher one.
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) id_o = ID_W'(i);
    end
  end

endmodule : irqc_prio_enc

// File: rtl/irqc_core.sv
// Programmable interrupt controller: synchronises external IRQ lines into the
// pending register IRR, masks with IMR and registers the winning request.
module irqc_core
  import irqc_pkg::*;
#(
  parameter int                        CONFIG_NUM_IRQ  = 32,
  parameter logic [CONFIG_NUM_IRQ-1:0] CONFIG_IRQ_EDGE = {CONFIG_NUM_IRQ{1'b1}},
  parameter int                        CONFIG_IRQ_ID_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CONFIG_NUM_IRQ-1:0]  irqs,
  input  logic [1:0]                 msr_addr,
  input  logic                       msr_we,
  input  logic [IRQC_DW-1:0]         msr_wdat,
  output logic [IRQC_DW-1:0]         msr_rdat,
  output logic [CONFIG_NUM_IRQ-1:0]  irqc_irr,
  output logic                       irq_req,
  output logic [CONFIG_IRQ_ID_W-1:0] irq_id
);

  logic [CONFIG_NUM_IRQ-1:0]  irr_q, irr_d;
  logic [CONFIG_NUM_IRQ-1:0]  imr_q, imr_d;
  logic [CONFIG_NUM_IRQ-1:0]  w1c, sw_set, pend;
  logic                       req_q;
  logic [CONFIG_IRQ_ID_W-1:0] id_q;
  logic                       enc_valid;
  logic [CONFIG_IRQ_ID_W-1:0] enc_id;
  logic                       wr_imr, wr_irr, wr_isr;

  assign wr_imr = msr_we && (msr_addr == IRQC_ADDR_IMR);
  assign wr_irr = msr_we && (msr_addr == IRQC_ADDR_IRR);
  assign wr_isr = msr_we && (msr_addr == IRQC_ADDR_ISR);

  assign w1c    = wr_irr ? msr_wdat[CONFIG_NUM_IRQ-1:0] : '0;
  assign sw_set = wr_isr ? msr_wdat[CONFIG_NUM_IRQ-1:0] : '0;
  assign imr_d  = wr_imr ? msr_wdat[CONFIG_NUM_IRQ-1:0] : imr_q;

  for (genvar i = 0; i < CONFIG_NUM_IRQ; i++) begin : g_line
    logic s1_q, s2_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source; blocking here would collapse
    // the two synchroniser stages into one.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
      end else begin
        s1_q <= irqs[i];
        s2_q <= s1_q;
      end
    end

    if (CONFIG_IRQ_EDGE[i]) begin : g_edge
      logic s3_q;

      always_ff @(posedge clk) begin
        if (!rst_n) s3_q <= 1'b0;
        else        s3_q <= s2_q;
      end

      // The set term is ORed after the clear so a coincident edge survives W1C.
      assign irr_d[i] = (irr_q[i] & ~w1c[i]) | (s2_q & ~s3_q) | sw_set[i];
    end else begin : g_level
      assign irr_d[i] = s2_q | sw_set[i];
    end
  end

  assign pend = irr_q & ~imr_q;

  irqc_prio_enc #(
    .W    (CONFIG_NUM_IRQ),
    .ID_W (CONFIG_IRQ_ID_W)
  ) u_prio_enc (
    .vec_i   (pend),
    .valid_o (enc_valid),
    .id_o    (enc_id)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irr_q <= '0;
      imr_q <= '1;
      req_q <= 1'b0;
      id_q  <= '0;
    end else begin
      irr_q <= irr_d;
      imr_q <= imr_d;
      req_q <= enc_valid;
      id_q  <= enc_id;
    end
  end

  always_comb begin
    msr_rdat = '0;
    case (msr_addr)
      IRQC_ADDR_IMR: msr_rdat = IRQC_DW'(imr_q);
      IRQC_ADDR_IRR: msr_rdat = IRQC_DW'(irr_q);
      default:       msr_rdat = '0;
    endcase
  end

  assign irqc_irr = irr_q;
  assign irq_req  = req_q;
  assign irq_id   = id_q;

endmodule : irqc_core

// File: tb/tb_irqc_core.sv
// Self-checking bench for irqc_core: a reference model predicts each cycle's
// outputs into a scoreboard queue that a negedge monitor drains and compares.
module tb_irqc_core;

  localparam logic [31:0] EDGE_CFG = 32'hFFFF_FFFE;  // line 0 is level-triggered

  typedef struct {
    logic [31:0] irr;
    logic        req;
    logic [4:0]  id;
    logic [31:0] rdat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] irqs;
  logic [1:0]  msr_addr;
  logic        msr_we;
  logic [31:0] msr_wdat;
  logic [31:0] msr_rdat;
  logic [31:0] irqc_irr;
  logic        irq_req;
  logic [4:0]  irq_id;

  irqc_core #(
    .CONFIG_NUM_IRQ  (32),
    .CONFIG_IRQ_EDGE (EDGE_CFG),
    .CONFIG_IRQ_ID_W (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irqs     (irqs),
    .msr_addr (msr_addr),
    .msr_we   (msr_we),
    .msr_wdat (msr_wdat),
    .msr_rdat (msr_rdat),
    .irqc_irr (irqc_irr),
    .irq_req  (irq_req),
    .irq_id   (irq_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  // Reference model state. hist1..hist3 are the line values sampled one, two
  // and three edges before the upcoming edge; IRR reacts to the line as it
  // looked two edges back, and a rising edge is "two back high, three back low".
  logic [31:0] m_irr, m_imr;
  logic        m_req;
  logic [4:0]  m_id;
  logic [31:0] hist1, hist2, hist3;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [4:0] lowest_pending(input logic [31:0] v);
    logic [4:0] r = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) begin
        r = 5'(i);
        break;
      end
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_irr = '0;
    m_imr = '1;
    m_req = 1'b0;
    m_id  = '0;
    hist1 = '0;
    hist2 = '0;
    hist3 = '0;
  endfunction

  // Entered and left at posedge+1: drive inputs, predict the outputs seen
  // during this cycle, then advance the model across the next edge.
  task automatic cycle(input logic [31:0] irq_v, input logic [1:0] a, input logic we,
                       input logic [31:0] d, input logic rst);
    exp_t        e;
    logic [31:0] w1c, sw, pend, n_irr, n_imr;
    irqs     = irq_v;
    msr_addr = a;
    msr_we   = we;
    msr_wdat = d;
    rst_n    = rst;

    e.irr  = m_irr;
    e.req  = m_req;
    e.id   = m_id;
    e.rdat = (a == 2'd0) ? m_imr : (a == 2'd1) ? m_irr : 32'h0;
    exp_q.push_back(e);

    w1c   = (we && a == 2'd1) ? d : 32'h0;
    sw    = (we && a == 2'd2) ? d : 32'h0;
    n_irr = (EDGE_CFG & ((m_irr & ~w1c) | (hist2 & ~hist3))) | (~EDGE_CFG & hist2) | sw;
    n_imr = (we && a == 2'd0) ? d : m_imr;
    pend  = m_irr & ~m_imr;

    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      m_req = (pend != 0);
      m_id  = lowest_pending(pend);
      m_irr = n_irr;
      m_imr = n_imr;
      hist3 = hist2;
      hist2 = hist1;
      hist1 = irq_v;
    end
    #1;
  endtask

  task automatic idle(input logic [31:0] irq_v);
    cycle(irq_v, 2'd1, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic expect_state(input string tag, input logic [31:0] irr,
                              input logic req, input logic [4:0] id);
    check({tag, "_irr"}, irqc_irr, irr);
    check({tag, "_req"}, 32'(irq_req), 32'(req));
    check({tag, "_id"}, 32'(irq_id), 32'(id));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("sb_irr", irqc_irr, e.irr);
      check("sb_req", 32'(irq_req), 32'(e.req));
      check("sb_id", 32'(irq_id), 32'(e.id));
      check("sb_rdat", msr_rdat, e.rdat);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    irqs = '0; msr_addr = '0; msr_we = 1'b0; msr_wdat = '0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // 1: reset state and register reads
    cycle(32'h0, 2'd0, 1'b1, 32'h0, 1'b0);
    cycle(32'h0, 2'd0, 1'b0, 32'h0, 1'b1);
    expect_state("t1", 32'h0, 1'b0, 5'd0);
    check("t1_imr", msr_rdat, 32'hFFFF_FFFF);
    idle(32'h0);
    check("t1_irr_read", msr_rdat, 32'h0);

    // 2: single pulse on line 3, then W1C
    cycle(32'h0, 2'd0, 1'b1, 32'h0, 1'b1);
    idle(32'h8);
    idle(32'h0);
    idle(32'h0);
    expect_state("t2_3rd", 32'h8, 1'b0, 5'd0);
    check("t2_irr_read", msr_rdat, 32'h8);
    idle(32'h0);
    expect_state("t2_req", 32'h8, 1'b1, 5'd3);
    cycle(32'h0, 2'd1, 1'b1, 32'h8, 1'b1);
    expect_state("t2_w1c", 32'h0, 1'b1, 5'd3);
    idle(32'h0);
    expect_state("t2_drop", 32'h0, 1'b0, 5'd0);

    // 3: lines 5 and 2 together, lowest wins, then the next one
    idle(32'h24);
    idle(32'h0);
    idle(32'h0);
    idle(32'h0);
    expect_state("t3_both", 32'h24, 1'b1, 5'd2);
    cycle(32'h0, 2'd1, 1'b1, 32'h4, 1'b1);
    idle(32'h0);
    expect_state("t3_next", 32'h20, 1'b1, 5'd5);
    cycle(32'h0, 2'd1, 1'b1, 32'h20, 1'b1);
    idle(32'h0);

    // 4: W1C coinciding with a synced edge on line 7 loses to the set
    idle(32'h80);
    idle(32'h80);
    cycle(32'h80, 2'd1, 1'b1, 32'h80, 1'b1);
    check("t4_set_wins", irqc_irr, 32'h80);
    cycle(32'h80, 2'd1, 1'b1, 32'h80, 1'b1);
    check("t4_w1c_later", irqc_irr, 32'h0);
    idle(32'h0);
    idle(32'h0);

    // 5: level line 0 ignores W1C while high and follows the line when it drops
    idle(32'h1);
    idle(32'h1);
    idle(32'h1);
    check("t5_level_set", irqc_irr, 32'h1);
    cycle(32'h1, 2'd1, 1'b1, 32'h1, 1'b1);
    check("t5_w1c_ignored", irqc_irr, 32'h1);
    idle(32'h0);
    idle(32'h0);
    idle(32'h0);
    check("t5_level_drop", irqc_irr, 32'h0);

    // 6: only line 0 unmasked with IRR = 3, then reset mid-run
    cycle(32'h1, 2'd0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    cycle(32'h1, 2'd2, 1'b1, 32'h2, 1'b1);
    idle(32'h1);
    check("t6_irr", irqc_irr, 32'h3);
    idle(32'h1);
    expect_state("t6_id0", 32'h3, 1'b1, 5'd0);
    cycle(32'h1, 2'd0, 1'b1, 32'h0, 1'b0);
    expect_state("t6_rst", 32'h0, 1'b0, 5'd0);
    check("t6_rst_imr", msr_rdat, 32'hFFFF_FFFF);

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] irq_v, d;
      logic [1:0]  a;
      logic        we, rst;
      irq_v = (n % 8 < 4) ? ($urandom & $urandom & $urandom) : irqs;
      a     = 2'($urandom_range(0, 3));
      we    = ($urandom_range(0, 3) == 0);
      d     = (a == 2'd0) ? ($urandom & $urandom) : $urandom;
      rst   = ($urandom_range(0, 99) != 0);
      cycle(irq_v, a, we, d, rst);
    end

    @(negedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_irqc_core
